wb_writer: RTL and testbench

Writeback-side driver of the register-file write port. It owns the MEM/WB pipeline register and the writeback data select. It also owns a small FIFO that queues results from long-latency units (divider, multiplier), so both sources share the register file's single write port. It emits `RFWr`/`A3`/`WD` directly to the register file and a per-register pending mask for the hazard unit.

---
 rtl/wb_writer.sv | 174 +++++++++++++++++
 tb/tb_wb_writer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_writer.sv
// wb_writer -- writeback-side driver of the register-file write port.
//
// The block owns the MEM/WB pipeline register, which selects the writeback
// data when it captures it. It also owns a small FIFO that queues results
// from long-latency units. One arbiter shares the single write port between
// the two sources. A starvation counter makes sure that a queued result
// cannot be locked out of the port indefinitely.
//
// Parameters:
//   FIFO_DEPTH   : long-latency queue depth (power of two, >= 2)
//   STARVE_LIMIT : lost arbitrations before a queued result stalls the pipe (1..15)
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   mem_valid/mem_rd/mem_wdsel   : MEM-stage write request, destination, data select
//   mem_alu/mem_rdata/mem_pc     : candidate writeback data sources
//   lu_valid/lu_ready            : long-latency result handshake
//   lu_rd/lu_data                : long-latency destination and result
//   RFWr/A3/WD                   : register-file write enable, address, data
//   stall_o                      : upstream must hold its MEM-stage outputs
//   pend_mask                    : bit n set while a queued entry targets register n
//
// Handshake: a long-latency result transfers on a rising edge where
// lu_valid & lu_ready are both 1. lu_ready depends only on the FIFO
// occupancy (and rst). It never depends on a pop in the same cycle, so no
// combinational path runs from the arbiter to the producer.
module wb_writer #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_wdsel,
  input  logic [31:0] mem_alu,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] mem_pc,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        RFWr,
  output logic [4:0]  A3,
  output logic [31:0] WD,
  output logic        stall_o,
  output logic [31:0] pend_mask
);

  localparam int          PW         = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_CNT  = (PW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

  // MEM/WB pipeline register
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  // Long-latency FIFO
  logic [4:0]    r_fifo_rd   [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  logic [3:0]    r_starve;

  logic          w_fifo_req;
  logic          w_full;
  logic          w_pipe_req;
  logic          w_push;
  logic          w_pop;
  logic          w_pipe_win;
  logic [31:0]   w_sel_data;
  logic [PW-1:0] w_off;

  assign w_fifo_req = (r_count != '0);
  assign w_full     = (r_count == DEPTH_CNT);
  // An rd=0 entry is architecturally a no-op and never claims the port.
  assign w_pipe_req = r_wb_valid && (r_wb_rd != 5'd0);

  assign lu_ready   = !rst && !w_full;
  // An accepted result aimed at x0 completes its handshake but is not stored.
  assign w_push     = lu_valid && lu_ready && (lu_rd != 5'd0);

  assign stall_o    = !rst && w_fifo_req && (r_starve == STARVE_MAX);
  // The FIFO wins when it is starving, or when the pipeline has nothing to write.
  assign w_pop      = !rst && w_fifo_req && (stall_o || !w_pipe_req);
  assign w_pipe_win = !rst && !w_pop && w_pipe_req;

  always_comb begin
    RFWr = 1'b0;
    A3   = 5'd0;
    WD   = 32'd0;
    if (w_pop) begin
      RFWr = 1'b1;
      A3   = r_fifo_rd[r_rd_ptr];
      WD   = r_fifo_data[r_rd_ptr];
    end else if (w_pipe_win) begin
      RFWr = 1'b1;
      A3   = r_wb_rd;
      WD   = r_wb_data;
    end
  end

  always_comb begin
    w_sel_data = mem_alu;
    case (mem_wdsel)
      2'b01:   w_sel_data = mem_rdata;
      2'b10:   w_sel_data = mem_pc + 32'd4;
      default: w_sel_data = mem_alu;
    endcase
  end

  // A slot is live when its distance from the read pointer is below the
  // occupancy. Duplicate destinations simply OR into the same bit.
  always_comb begin
    pend_mask = 32'd0;
    w_off     = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_off = PW'(i) - r_rd_ptr;
      if ({1'b0, w_off} < r_count) begin
        pend_mask[r_fifo_rd[i]] = 1'b1;
      end
    end
  end

  // The FIFO storage carries no reset. Occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= lu_rd;
      r_fifo_data[r_wr_ptr] <= lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'd0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_starve   <= 4'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase

      // Count the cycles that the head entry loses to the pipeline.
      if (w_pop || !w_fifo_req) begin
        r_starve <= 4'd0;
      end else if (w_pipe_win) begin
        r_starve <= r_starve + 4'd1;
      end

      // A stall freezes the entry so it is written on the next cycle.
      if (!stall_o) begin
        r_wb_valid <= mem_valid;
        r_wb_rd    <= mem_rd;
        r_wb_data  <= w_sel_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_writer.sv
// Testbench for wb_writer.
// The reference model keeps the queued long-latency results as a queue of
// {rd, data} records. It keeps the MEM/WB write that is still to be done as a
// scoreboard queue (exp_q). From these two queues it predicts, every cycle,
// which source owns the write port.
module tb_wb_writer;

  localparam int DEPTH = 2;
  localparam int SLIM  = 3;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wdsel;
  logic [31:0] mem_alu;
  logic [31:0] mem_rdata;
  logic [31:0] mem_pc;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        RFWr;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic        stall_o;
  logic [31:0] pend_mask;

  wb_writer #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_wdsel(mem_wdsel),
    .mem_alu(mem_alu), .mem_rdata(mem_rdata), .mem_pc(mem_pc),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .RFWr(RFWr), .A3(A3), .WD(WD), .stall_o(stall_o), .pend_mask(pend_mask)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        m_q[$];     // queued long-latency results, oldest first
  logic [36:0] exp_q[$];   // pipeline write still owed: {rd, data}
  int          m_starve;

  // Decisions the model made at the sampling point. They are reused at the edge.
  bit e_stall, e_ready, fifo_win, pipe_win;

  // Snapshot of DUT outputs at the last sampling point.
  logic        s_rfwr, s_stall, s_ready;
  logic [4:0]  s_a3;
  logic [31:0] s_wd, s_mask;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] wb_data(logic [1:0] sel, logic [31:0] alu,
                                          logic [31:0] rdata, logic [31:0] pc);
    if (sel == 2'b01) return rdata;
    if (sel == 2'b10) return pc + 32'd4;
    return alu;
  endfunction

  // Compare at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    bit          fifo_req, pipe_req, e_rfwr;
    logic [4:0]  e_a3;
    logic [31:0] e_wd, e_mask;
    @(negedge clk);
    fifo_req = (m_q.size() != 0);
    pipe_req = (exp_q.size() != 0);
    e_stall  = !rst && fifo_req && (m_starve == SLIM);
    fifo_win = !rst && fifo_req && (e_stall || !pipe_req);
    pipe_win = !rst && !fifo_win && pipe_req;
    e_ready  = !rst && (m_q.size() < DEPTH);
    e_rfwr = 1'b0; e_a3 = 5'd0; e_wd = 32'd0;
    if (fifo_win) begin
      e_rfwr = 1'b1; e_a3 = m_q[0].rd; e_wd = m_q[0].d;
    end else if (pipe_win) begin
      e_rfwr = 1'b1; e_a3 = exp_q[0][36:32]; e_wd = exp_q[0][31:0];
    end
    e_mask = 32'd0;
    foreach (m_q[k]) e_mask[m_q[k].rd] = 1'b1;

    s_rfwr = RFWr; s_a3 = A3; s_wd = WD; s_stall = stall_o;
    s_ready = lu_ready; s_mask = pend_mask;
    check("rfwr", s_rfwr, e_rfwr);
    check("a3", s_a3, e_a3);
    check("wd", s_wd, e_wd);
    check("stall", s_stall, e_stall);
    check("lu_ready", s_ready, e_ready);
    check("pend_mask", s_mask, e_mask);

    @(posedge clk);
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_starve = 0;
    end else begin
      if (fifo_win) begin
        void'(m_q.pop_front());
        m_starve = 0;
      end else if (pipe_win && fifo_req) begin
        m_starve++;
      end else begin
        m_starve = 0;
      end
      if (lu_valid && e_ready && lu_rd != 5'd0) m_q.push_back('{rd: lu_rd, d: lu_data});
      if (!e_stall) begin
        exp_q.delete();
        if (mem_valid && mem_rd != 5'd0)
          exp_q.push_back({mem_rd, wb_data(mem_wdsel, mem_alu, mem_rdata, mem_pc)});
      end
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    mem_valid = 1'b0; mem_rd = 5'd0; mem_wdsel = 2'b00;
    mem_alu = 32'd0; mem_rdata = 32'd0; mem_pc = 32'd0;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
  endtask

  task automatic drive_random();
    rst       = ($urandom_range(0, 99) == 0);
    mem_valid = ($urandom_range(0, 3) != 0);
    mem_rd    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
    mem_wdsel = 2'($urandom);
    mem_alu   = $urandom;
    mem_rdata = $urandom;
    mem_pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
    lu_valid  = ($urandom_range(0, 2) == 0);
    lu_rd     = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 12));
    lu_data   = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_starve = 0;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset while both sources are requesting.
    mem_valid = 1'b1; mem_rd = 5'd2; mem_alu = 32'h1234;
    lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'h5678;
    repeat (2) begin
      cycle();
      check("rst_rfwr", s_rfwr, 1'b0);
      check("rst_ready", s_ready, 1'b0);
    end
    rst = 1'b0;
    idle();
    cycle();
    check("release_rfwr", s_rfwr, 1'b0);
    check("release_ready", s_ready, 1'b1);
    check("release_mask", s_mask, 32'd0);

    // PC+4 select, including the wrap-around at the top of the address space.
    mem_valid = 1'b1; mem_rd = 5'd5; mem_wdsel = 2'b10; mem_pc = 32'h0000_0100;
    cycle();
    mem_pc = 32'hFFFF_FFFC;
    cycle();
    check("pc4_rfwr", s_rfwr, 1'b1);
    check("pc4_a3", s_a3, 5'd5);
    check("pc4_wd", s_wd, 32'h0000_0104);
    idle();
    cycle();
    check("pc4_wrap_wd", s_wd, 32'd0);

    // A single long-latency result with the pipeline idle.
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'hDEAD_BEEF;
    cycle();
    idle();
    cycle();
    check("lu_mask", s_mask, 32'h80);
    check("lu_a3", s_a3, 5'd7);
    check("lu_wd", s_wd, 32'hDEAD_BEEF);
    cycle();
    check("lu_mask_clear", s_mask, 32'd0);

    // Back-pressure and starvation under continuous pipeline writes to x1.
    mem_valid = 1'b1; mem_rd = 5'd1; mem_alu = 32'h11;
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h9009;
    cycle();
    lu_rd = 5'd10; lu_data = 32'hA00A; mem_alu = 32'h22;
    cycle();
    lu_rd = 5'd11; lu_data = 32'hB00B; mem_alu = 32'h33;
    cycle();
    check("bp_ready_full", s_ready, 1'b0);
    check("bp_pipe_wins", s_a3, 5'd1);
    mem_alu = 32'h44;
    cycle();
    check("starve_no_stall_yet", s_stall, 1'b0);
    mem_alu = 32'h55;
    cycle();
    check("starve_stall", s_stall, 1'b1);
    check("starve_a3", s_a3, 5'd9);
    check("starve_wd", s_wd, 32'h9009);
    mem_alu = 32'h66;
    cycle();
    check("held_a3", s_a3, 5'd1);
    check("held_wd", s_wd, 32'h44);
    check("third_accepted", s_ready, 1'b1);
    lu_valid = 1'b0;
    repeat (12) cycle();
    idle();
    repeat (4) cycle();
    check("drain_mask", s_mask, 32'd0);

    // x0 handling: the MEM/WB entry for x0 lets the FIFO take the port.
    mem_valid = 1'b1; mem_rd = 5'd0;
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h3333;
    cycle();
    lu_valid = 1'b0;
    cycle();
    check("x0_fifo_a3", s_a3, 5'd3);
    check("x0_fifo_rfwr", s_rfwr, 1'b1);
    idle();
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hBAD0;
    cycle();
    check("lu_x0_ready", s_ready, 1'b1);
    idle();
    cycle();
    check("lu_x0_mask", s_mask, 32'd0);
    check("lu_x0_rfwr", s_rfwr, 1'b0);

    // Reset with two entries queued behind pipeline traffic.
    mem_valid = 1'b1; mem_rd = 5'd1; mem_alu = 32'h77;
    lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'hC00C;
    cycle();
    lu_rd = 5'd13; lu_data = 32'hD00D;
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    check("midrst_rfwr", s_rfwr, 1'b0);
    cycle();
    check("midrst_mask", s_mask, 32'd0);
    rst = 1'b0;
    repeat (3) begin
      cycle();
      check("post_rst_rfwr", s_rfwr, 1'b0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      cycle();
    end
    rst = 1'b0;
    idle();
    repeat (10) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
